// File: rtl/sda_pkg.sv
// Shared definitions for the serial-to-parallel receiver and its upstream serialiser.
package sda_pkg;

  localparam int unsigned DW_DEF   = 4;
  localparam logic        IDLE_LVL = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    WAIT_STOP = 2'd2
  } state_e;

endpackage : sda_pkg

// File: rtl/sda_cond_det.sv
// Bus condition decoder: keeps the previous scl/sda samples and flags start, stop
// and scl rising edges, all relative to the system clock.
module sda_cond_det
  import sda_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic start_c,
  output logic stop_c,
  output logic rise_c
);

  logic scl_q;
  logic sda_q;

  // Previous samples; reset to the idle bus level so release cannot fake a condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= IDLE_LVL;
      sda_q <= IDLE_LVL;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
    end
  end

  // Decode sda transitions while scl is held high, and scl low-to-high edges.
  always_comb begin
    start_c = scl_q & scl_i & sda_q & ~sda_i;
    stop_c  = scl_q & scl_i & ~sda_q & sda_i;
    rise_c  = ~scl_q & scl_i;
  end

endmodule : sda_cond_det

// File: rtl/sda_to_par.sv
// Serial-to-parallel frame receiver with one-hot decode of the received value.
// Optional feature: define SDA_RX_ERR_CNT_EN to add the saturating err_cnt port.
module sda_to_par
  import sda_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               scl,
  input  logic               sda,
  output logic [DW-1:0]      data_q,
  output logic [2**DW-1:0]   out_hot,
  output logic               frame_valid,
  output logic               frame_err
`ifdef SDA_RX_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  localparam int unsigned HW  = 2**DW;
  localparam int unsigned BCW = $clog2(DW) + 1;

  logic           start_c;
  logic           stop_c;
  logic           rise_c;

  state_e         state_q, state_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic [DW-1:0]  data_d;
  logic [HW-1:0]  hot_d;
  logic           valid_d;
  logic           err_d;

  sda_cond_det u_cond (
    .clk     (sclk),
    .rst_n   (rst),
    .scl_i   (scl),
    .sda_i   (sda),
    .start_c (start_c),
    .stop_c  (stop_c),
    .rise_c  (rise_c)
  );

  // Frame FSM state, bit counter, shift register and registered outputs.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      out_hot     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      out_hot     <= hot_d;
      frame_valid <= valid_d;
      frame_err   <= err_d;
    end
  end

  // Next-state logic; start outranks stop and rise, and rise is ignored once all bits are in.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    hot_d   = out_hot;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = DATA;
          bcnt_d  = '0;
          shreg_d = '0;
        end
      end
      DATA: begin
        if (start_c) begin
          bcnt_d  = '0;
          shreg_d = '0;
          err_d   = 1'b1;
        end else if (stop_c) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (rise_c) begin
          shreg_d = DW'({shreg_q, sda});
          bcnt_d  = bcnt_q + BCW'(1);
          if (bcnt_d == BCW'(DW)) begin
            state_d = WAIT_STOP;
          end
        end
      end
      WAIT_STOP: begin
        if (start_c) begin
          state_d = DATA;
          bcnt_d  = '0;
          shreg_d = '0;
          err_d   = 1'b1;
        end else if (stop_c) begin
          state_d = IDLE;
          data_d  = shreg_q;
          hot_d   = HW'(1) << shreg_q;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SDA_RX_ERR_CNT_EN
  // Aborted-frame counter, saturating at its maximum.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_d && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule : sda_to_par

// File: doc/sda_to_par.md
SDA_TO_PAR -- requirements
Module: sda_to_par

Interface
REQ-001 Parameter DW, default 4, sets the frame data bits; the decoded output width is 2**DW.
REQ-002 sclk  input  1  system clock; scl is sampled and all state is updated on the posedge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 scl  input  1  serial clock from the upstream serialiser; it is synchronous to sclk.
REQ-005 sda  input  1  serial data from the upstream serialiser; it is synchronous to sclk.
REQ-006 data_q  output  DW  last complete frame value.
REQ-007 out_hot  output  2**DW  one-hot decode of data_q.
REQ-008 frame_valid  output  1  one-sclk pulse when a complete frame is accepted.
REQ-009 frame_err  output  1  one-sclk pulse when a frame is aborted.
REQ-010 err_cnt  output  8  count of aborted frames; this port is present only under the macro in REQ-026.

Function
REQ-011 The block SHALL register the previous samples scl_d and sda_d each posedge and derive the bus conditions from them:
- start: scl_d=1, scl=1, sda_d=1, sda=0.
- stop: scl_d=1, scl=1, sda_d=0, sda=1.
- rise: scl_d=0, scl=1.
REQ-012 The FSM states SHALL be IDLE, DATA and WAIT_STOP, with a bit counter bcnt of width clog2(DW)+1.
REQ-013 IDLE SHALL go to DATA on start, with bcnt=0 and the shift register cleared; all other conditions are ignored.
REQ-014 In DATA, each rise SHALL shift sda into the LSB (MSB first) and increment bcnt; when bcnt reaches DW the FSM goes to WAIT_STOP.
REQ-015 In WAIT_STOP, rise SHALL be ignored (the stop preamble raises scl with sda low), and stop SHALL complete the frame.
REQ-016 On frame completion, at the same posedge where stop is detected:
- data_q is loaded from the shift register.
- out_hot is set to 1<<shift register.
- frame_valid is high for exactly one cycle.
- the FSM returns to IDLE.
REQ-017 A stop in DATA (fewer than DW bits) SHALL pulse frame_err for one cycle, return to IDLE, and leave data_q and out_hot unchanged.
REQ-018 A start in DATA or WAIT_STOP SHALL be a restart: bcnt and the shift register are cleared, the FSM stays in or enters DATA, frame_err pulses, and the outputs are unchanged.
REQ-019 start and stop are mutually exclusive by construction; when rise and start coincide, start SHALL take priority.
REQ-020 data_q and out_hot SHALL hold their values between frames; out_hot has exactly one bit set after the first valid frame and is all zero before it.
REQ-021 Back-to-back frames (a stop followed by a start one scl period later) SHALL be accepted with no lost frame.

Reset
REQ-022 Reset assertion SHALL take effect immediately, independent of sclk.
REQ-023 In reset:
- state=IDLE, bcnt=0, shift register=0.
- data_q=0, out_hot=0.
- frame_valid=0, frame_err=0, err_cnt=0.
REQ-024 In reset, scl_d=1 and sda_d=1 (idle bus) so that reset release cannot produce a false start or stop.
REQ-025 Reset mid-frame SHALL discard the partial frame and produce no valid or err pulse.

Configuration
REQ-026 With SDA_RX_ERR_CNT_EN defined, err_cnt SHALL increment on every frame_err pulse and saturate at 255.
REQ-027 Without SDA_RX_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-028 Shared package sda_pkg SHALL hold:
- the FSM state typedef (IDLE, DATA, WAIT_STOP);
- the DW default constant;
- the idle bus level constant (1'b1).
REQ-029 The upstream serialiser SHALL import the same package.
REQ-030 One sub-module, sda_cond_det, SHALL contain scl_d/sda_d and the start/stop/rise decode; the FSM, shift register and decoder SHALL sit in sda_to_par.

Verification
REQ-031 Start, bits 1,0,1,0, stop -> data_q=4'hA, out_hot=16'h0400, and frame_valid high for exactly 1 cycle at stop detection.
REQ-032 Start, bits 1,1, stop -> frame_err for 1 cycle, data_q and out_hot keep their prior values, and FSM=IDLE.
REQ-033 Start, bits 1,0, restart, bits 0,0,1,1, stop -> one frame_err pulse, then data_q=4'h3 and out_hot=16'h0008.
REQ-034 Back-to-back frames 4'h0 then 4'hF -> out_hot=16'h0001 then 16'h8000, with two frame_valid pulses.
REQ-035 rst asserted after 2 bits, released, then a full frame 4'h5 -> all outputs 0 during reset, no pulse for the aborted frame, then out_hot=16'h0020.
REQ-036 With SDA_RX_ERR_CNT_EN, 260 aborted frames -> err_cnt=255 and held there.
